imem_sync_loadable: RTL and testbench

Parametrised successor to the core's instruction memory. Provides a registered, synchronous-read fetch port with stall and flush, plus a program-load port so the image is written at run time instead of being hard-wired. Adds byte-address decoding with misalignment and out-of-range fault reporting. Sits between the IF-stage PC register and the IF/ID pipeline register.

---
 rtl/imem_pkg.sv | 19 +
 rtl/imem_ram.sv | 33 +++
 rtl/imem_sync_loadable.sv | 161 ++++++++++++++++
 tb/tb_imem_sync_loadable.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the loadable instruction memory.
//   NOP_WORD_DEFAULT : fill/bubble instruction (addi x0,x0,0)
//   state_t          : controller phases CLEAR -> LOAD -> RUN
//   FC_*             : fault_cause encodings reported on a faulting fetch
package imem_pkg;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_RANGE    = 2'b10;

endpackage

// File: rtl/imem_ram.sv
// DEPTH x 32 storage with one write port and one synchronous read port.
// Storage has no reset; the parent's CLEAR pass initialises it.
//   clk     : clock
//   i_we    : write strobe
//   i_waddr : write word index
//   i_wdata : write data
//   i_re    : read enable; o_rdata holds its value while low
//   i_raddr : read word index
//   o_rdata : registered read data
module imem_ram #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [0:DEPTH-1];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_sync_loadable.sv
// Run-time loadable instruction memory with a registered fetch port.
// After reset the array is filled with NOP_WORD (CLEAR, DEPTH cycles), then
// words are written through the program port (LOAD) until prog_done, after
// which the fetch port serves byte-addressed requests with stall/flush and
// misalignment / out-of-range fault reporting (RUN).
//   clk, reset                    : clock, async active-high reset
//   prog_we/prog_addr/prog_data   : load-phase word write
//   prog_done                     : ends LOAD
//   ready                         : high in RUN
//   fetch_en, pc, stall, flush    : fetch request controls
//   instr, instr_valid, fault,
//   fault_cause                   : fetch response, one cycle after request
module imem_sync_loadable
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned ADDR_W   = 32,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [31:0]              prog_data,
  input  logic                     prog_done,
  output logic                     ready,
  input  logic                     fetch_en,
  input  logic [ADDR_W-1:0]        pc,
  input  logic                     stall,
  input  logic                     flush,
  output logic [31:0]              instr,
  output logic                     instr_valid,
  output logic                     fault,
  output logic [1:0]               fault_cause
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [ADDR_W-3:0] IDX_LIMIT   = (ADDR_W-2)'(DEPTH);
  localparam logic [AW:0]       PADDR_LIMIT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]     CLR_LAST    = AW'(DEPTH - 1);

  state_t            r_state;
  state_t            w_next_state;
  logic [AW-1:0]     r_clr_cnt;

  logic              w_we;
  logic [AW-1:0]     w_waddr;
  logic [31:0]       w_wdata;
  logic              w_re;
  logic [31:0]       w_rdata;

  logic [ADDR_W-3:0] w_idx;
  logic              w_misalign;
  logic              w_range;
  logic              w_accept;

  logic              r_from_mem;
  logic              r_valid;
  logic              r_fault;
  logic [1:0]        r_cause;

  // Full-width index compare: high pc bits are never dropped.
  assign w_idx      = pc[ADDR_W-1:2];
  assign w_misalign = |pc[1:0];
  assign w_range    = (w_idx >= IDX_LIMIT);
  assign w_accept   = (r_state == ST_RUN) && !flush && !stall && fetch_en;
  // RAM read only fires for a good fetch; with re low its output register
  // holds, which is what keeps instr stable during stall.
  assign w_re       = w_accept && !w_misalign && !w_range;

  always_comb begin
    w_next_state = r_state;
    w_we         = 1'b0;
    w_waddr      = prog_addr;
    w_wdata      = prog_data;
    case (r_state)
      ST_CLEAR: begin
        w_we    = 1'b1;
        w_waddr = r_clr_cnt;
        w_wdata = NOP_WORD;
        if (r_clr_cnt == CLR_LAST) w_next_state = ST_LOAD;
      end
      ST_LOAD: begin
        w_we = prog_we && ({1'b0, prog_addr} < PADDR_LIMIT);
        if (prog_done) w_next_state = ST_RUN;
      end
      ST_RUN:  w_next_state = ST_RUN;
      default: w_next_state = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_next_state;
      r_clr_cnt <= (r_state == ST_CLEAR) ? r_clr_cnt + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_from_mem <= 1'b0;
      r_valid    <= 1'b0;
      r_fault    <= 1'b0;
      r_cause    <= FC_NONE;
    end else if (r_state != ST_RUN || flush) begin
      r_from_mem <= 1'b0;
      r_valid    <= 1'b0;
      r_fault    <= 1'b0;
      r_cause    <= FC_NONE;
    end else if (stall) begin
      r_from_mem <= r_from_mem;
      r_valid    <= r_valid;
      r_fault    <= r_fault;
      r_cause    <= r_cause;
    end else if (fetch_en) begin
      r_valid <= 1'b1;
      if (w_misalign) begin
        r_from_mem <= 1'b0;
        r_fault    <= 1'b1;
        r_cause    <= FC_MISALIGN;
      end else if (w_range) begin
        r_from_mem <= 1'b0;
        r_fault    <= 1'b1;
        r_cause    <= FC_RANGE;
      end else begin
        r_from_mem <= 1'b1;
        r_fault    <= 1'b0;
        r_cause    <= FC_NONE;
      end
    end else begin
      r_from_mem <= 1'b0;
      r_valid    <= 1'b0;
      r_fault    <= 1'b0;
      r_cause    <= FC_NONE;
    end
  end

  imem_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_re),
    .i_raddr (w_idx[AW-1:0]),
    .o_rdata (w_rdata)
  );

  // Bubble/fault responses select the constant; only good fetches use RAM data.
  assign instr       = r_from_mem ? w_rdata : NOP_WORD;
  assign instr_valid = r_valid;
  assign fault       = r_fault;
  assign fault_cause = r_cause;
  assign ready       = (r_state == ST_RUN);

endmodule

// File: tb/tb_imem_sync_loadable.sv
module tb_imem_sync_loadable;

  localparam int unsigned DEPTH = 12;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic        valid;
    logic        fault;
    logic [1:0]  cause;
    logic        ready;
  } resp_t;

  typedef enum int {M_CLEAR, M_LOAD, M_RUN} mode_t;

  logic          clk;
  logic          reset;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [31:0]   prog_data;
  logic          prog_done;
  logic          ready;
  logic          fetch_en;
  logic [31:0]   pc;
  logic          stall;
  logic          flush;
  logic [31:0]   instr;
  logic          instr_valid;
  logic          fault;
  logic [1:0]    fault_cause;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  resp_t       exp_q[$];
  resp_t       last_exp;
  logic [31:0] m_mem [0:DEPTH-1];
  mode_t       m_mode;
  int unsigned m_cnt;

  imem_sync_loadable #(
    .DEPTH  (DEPTH),
    .ADDR_W (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_done   (prog_done),
    .ready       (ready),
    .fetch_en    (fetch_en),
    .pc          (pc),
    .stall       (stall),
    .flush       (flush),
    .instr       (instr),
    .instr_valid (instr_valid),
    .fault       (fault),
    .fault_cause (fault_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    prog_we = 0; prog_addr = '0; prog_data = '0; prog_done = 0;
    fetch_en = 0; pc = '0; stall = 0; flush = 0;
  endtask

  task automatic model_reset();
    m_mode = M_CLEAR;
    m_cnt  = 0;
    for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = NOP;
    last_exp = '{instr: NOP, valid: 1'b0, fault: 1'b0, cause: 2'b00, ready: 1'b0};
    exp_q.delete();
  endtask

  // Predict the response to the current inputs, queue it, advance one edge.
  task automatic drive_edge();
    resp_t e;
    e = '{instr: NOP, valid: 1'b0, fault: 1'b0, cause: 2'b00, ready: 1'b0};
    if (m_mode == M_RUN && !flush) begin
      if (stall) e = last_exp;
      else if (fetch_en) begin
        e.valid = 1'b1;
        if (pc[1:0] != 2'b00) begin
          e.fault = 1'b1; e.cause = 2'b01;
        end else if ((pc >> 2) >= DEPTH) begin
          e.fault = 1'b1; e.cause = 2'b10;
        end else begin
          e.instr = m_mem[pc >> 2];
        end
      end
    end
    case (m_mode)
      M_CLEAR: begin
        m_cnt++;
        if (m_cnt == DEPTH) m_mode = M_LOAD;
      end
      M_LOAD: begin
        if (prog_we && prog_addr < DEPTH) m_mem[prog_addr] = prog_data;
        if (prog_done) m_mode = M_RUN;
      end
      default: ;
    endcase
    e.ready  = (m_mode == M_RUN);
    last_exp = e;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resp_t got;
    idle_inputs();
    reset = 1'b1;
    model_reset();
    #2;
    got = {instr, instr_valid, fault, fault_cause, ready};
    n_checks++;
    if (got !== last_exp) begin
      n_errors++;
      $display("FAIL reset_state: got %h expected %h", got, last_exp);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock.
  task automatic test_async_reset(input string tag);
    resp_t got, e;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    got = {instr, instr_valid, fault, fault_cause, ready};
    e   = '{instr: NOP, valid: 1'b0, fault: 1'b0, cause: 2'b00, ready: 1'b0};
    n_checks++;
    if (got !== e) begin
      n_errors++;
      $display("FAIL async_reset_%s: got %h expected %h", tag, got, e);
    end
    idle_inputs();
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Full CLEAR pass with load/fetch inputs active; they must be ignored.
  task automatic test_clear_pass(input bit hold_done);
    resp_t got, e;
    for (int i = 0; i < int'(DEPTH); i++) begin
      prog_we = 1; prog_addr = AW'(i % DEPTH); prog_data = 32'hBAD0_0000 + i;
      prog_done = hold_done; fetch_en = 1; pc = 32'(i * 4);
      if (i == int'(DEPTH) - 1) prog_we = 0;
      drive_edge();
      got = {instr, instr_valid, fault, fault_cause, ready};
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_errors++;
        $display("FAIL clear_pass[%0d]: got %h expected %h", i, got, e);
      end
    end
    fetch_en = 0; pc = '0;
  endtask

  task automatic test_first_fetch();
    resp_t got, e;
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      if (i == 0) prog_done = 1;
      if (i == 1) begin fetch_en = 1; pc = 32'h0; end
      drive_edge();
      got = {instr, instr_valid, fault, fault_cause, ready};
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_errors++;
        $display("FAIL first_fetch[%0d]: got %h expected %h", i, got, e);
      end
    end
  endtask

  task automatic test_load_fetch();
    resp_t got, e;
    logic [31:0] words [0:3];
    words[0] = 32'h3990_0313; words[1] = 32'h0060_2223;
    words[2] = 32'h0040_0283; words[3] = 32'hDEAD_BEEF;
    for (int i = 0; i < 12; i++) begin
      idle_inputs();
      case (i)
        0, 1, 2: begin
          prog_we = 1; prog_addr = AW'(i); prog_data = words[i];
          fetch_en = 1; pc = 32'h0;
        end
        3: begin
          prog_we = 1; prog_addr = AW'(DEPTH - 1); prog_data = words[3]; prog_done = 1;
        end
        4: begin prog_we = 1; prog_addr = '0; prog_data = 32'hFFFF_FFFF; end
        5: begin fetch_en = 1; pc = 32'h0; end
        6: begin fetch_en = 1; pc = 32'h4; end
        7: begin fetch_en = 1; pc = 32'h8; end
        8: ;
        9: begin fetch_en = 1; pc = (DEPTH - 1) * 4; end
        10: begin fetch_en = 1; pc = 32'hC; end
        default: ;
      endcase
      drive_edge();
      got = {instr, instr_valid, fault, fault_cause, ready};
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_errors++;
        $display("FAIL load_fetch[%0d]: got %h expected %h", i, got, e);
      end
    end
  endtask

  task automatic test_faults();
    resp_t got, e;
    logic [31:0] pcs [0:6];
    pcs[0] = 32'h6;            pcs[1] = DEPTH * 4;
    pcs[2] = DEPTH * 4 + 2;    pcs[3] = 32'h4000_0000;
    pcs[4] = 32'h1;            pcs[5] = (DEPTH - 1) * 4;
    pcs[6] = 32'h4000_0004;
    for (int i = 0; i < 7; i++) begin
      idle_inputs();
      fetch_en = 1; pc = pcs[i];
      drive_edge();
      got = {instr, instr_valid, fault, fault_cause, ready};
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_errors++;
        $display("FAIL faults[%0d] pc=%h: got %h expected %h", i, pcs[i], got, e);
      end
    end
  endtask

  task automatic test_stall();
    resp_t got, e;
    for (int i = 0; i < 7; i++) begin
      idle_inputs();
      fetch_en = 1;
      case (i)
        0: pc = 32'h4;
        1, 2, 3: begin pc = 32'h8; stall = 1; end
        4: pc = 32'h8;
        5: begin pc = 32'h6; end
        default: begin pc = 32'h0; stall = 1; end
      endcase
      drive_edge();
      got = {instr, instr_valid, fault, fault_cause, ready};
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_errors++;
        $display("FAIL stall[%0d]: got %h expected %h", i, got, e);
      end
    end
  endtask

  task automatic test_flush();
    resp_t got, e;
    for (int i = 0; i < 5; i++) begin
      idle_inputs();
      fetch_en = 1;
      case (i)
        0: pc = 32'h8;
        1: begin pc = 32'h4; flush = 1; stall = 1; end
        2: pc = 32'h6;
        3: begin pc = 32'h0; flush = 1; end
        default: pc = 32'h0;
      endcase
      drive_edge();
      got = {instr, instr_valid, fault, fault_cause, ready};
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_errors++;
        $display("FAIL flush[%0d]: got %h expected %h", i, got, e);
      end
    end
  endtask

  // After a reset and an empty reload every word reads back as NOP.
  task automatic test_reload_empty();
    resp_t got, e;
    for (int i = 0; i < 5; i++) begin
      idle_inputs();
      case (i)
        0: prog_done = 1;
        1: begin fetch_en = 1; pc = 32'h0; end
        2: begin fetch_en = 1; pc = 32'h4; end
        3: begin fetch_en = 1; pc = 32'h8; end
        default: begin fetch_en = 1; pc = (DEPTH - 1) * 4; end
      endcase
      drive_edge();
      got = {instr, instr_valid, fault, fault_cause, ready};
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_errors++;
        $display("FAIL reload_empty[%0d]: got %h expected %h", i, got, e);
      end
    end
  endtask

  task automatic load_one_word();
    resp_t got, e;
    idle_inputs();
    prog_we = 1; prog_addr = '0; prog_data = 32'h3990_0313;
    drive_edge();
    got = {instr, instr_valid, fault, fault_cause, ready};
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin
      n_errors++;
      $display("FAIL load_before_reset: got %h expected %h", got, e);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_clear_pass(1'b1);
    test_first_fetch();
    test_async_reset("after_first");
    test_clear_pass(1'b0);
    test_load_fetch();
    test_faults();
    test_stall();
    test_flush();
    test_async_reset("mid_run");
    test_clear_pass(1'b0);
    load_one_word();
    test_async_reset("mid_load");
    test_clear_pass(1'b0);
    test_reload_empty();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
